// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state enum, the "no grant" index code and one-hot decode.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } arb_state_e;

  localparam logic [7:0] NO_GRANT  = 8'hF0;
  localparam int         N_REQ_DEF = 16;
  localparam int         MAX_REQ   = 16;

  // Zero vector maps to the shared "none" code.
  function automatic logic [7:0] onehot_to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [7:0] idx;
    idx = NO_GRANT;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mask_encoder.sv
// Rotating winner search: highest index below last_ptr first,
// falling back to the highest index of the full request vector.
module rr_mask_encoder #(
  parameter int N_REQ = 16,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] last_ptr_i,
  output logic [PTR_W-1:0] win_o,
  output logic             found_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [PTR_W-1:0] win_m;
  logic [PTR_W-1:0] win_f;
  logic             hit_m;
  logic             hit_f;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (PTR_W'(i) < last_ptr_i);
    end
    masked = req_i & mask;
  end

  // Ascending scan so the last hit is the highest index.
  always_comb begin
    win_m = '0;
    hit_m = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (masked[i]) begin
        win_m = PTR_W'(i);
        hit_m = 1'b1;
      end
    end
  end

  always_comb begin
    win_f = '0;
    hit_f = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i]) begin
        win_f = PTR_W'(i);
        hit_f = 1'b1;
      end
    end
  end

  assign win_o   = hit_m ? win_m : win_f;
  assign found_o = hit_f;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter holding one grant until the owner releases.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [7:0]       busy_cycles
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
  logic [7:0]       busy_q, busy_d;

  logic [PTR_W-1:0] win;
  logic             found;
  logic             timeout;

  rr_mask_encoder #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_enc (
    .req_i      (req),
    .last_ptr_i (last_ptr_q),
    .win_o      (win),
    .found_o    (found)
  );

  assign timeout = TO_EN && (busy_q == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      busy_q     <= busy_d;
    end
  end

  // last_ptr doubles as the owner index while in HOLD.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = HOLD;
          grant_d    = N_REQ'(1) << win;
          last_ptr_d = win;
          busy_d     = '0;
        end
      end
      HOLD: begin
        if (!req[last_ptr_q] || timeout) begin
          state_d = RELEASE;
          grant_d = '0;
          busy_d  = '0;
        end else if (busy_q != 8'hFF) begin
          busy_d = busy_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(grant_q)));
  assign busy_cycles = busy_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- 16-requester round-robin arbiter.
- Shares one downstream resource among requesters; grants exactly one at a time and holds the grant until the owner releases.
- Arbitration core is a masked priority encoder that searches from the highest index first.
- Outputs a one-hot grant plus an encoded index; the encoded index uses the same "none" code (8'hF0) as the team's priority encoder.

Parameters:
- N_REQ, 16, number of requesters; fixed power of two, 2..16.
- IDX_W, 8, width of the encoded grant index.
- MAX_HOLD, 15, maximum grant-hold cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request vector; bit i high = requester i wants the resource.
- grant  output  N_REQ  one-hot grant, registered.
- grant_valid  output  1  high while any grant is held.
- grant_idx  output  IDX_W  index of the current owner; 8'hF0 when there is no grant.
- busy_cycles  output  8  cycles the current owner has held the grant; saturates at 255.

Behaviour:
- Reset (rst high at a clock edge):
  - grant=0, grant_valid=0, grant_idx=8'hF0, busy_cycles=0.
  - last_ptr=0, state=IDLE.
  - Reset overrides everything, including an active grant mid-hold; that grant drops on the next edge.
- Priority order after last grant k: k-1, k-2, …, 0, N_REQ-1, …, k.
  - With last_ptr=0 after reset, the first arbitration is pure highest-index-first (15 down to 0).
- FSM states: IDLE, HOLD, RELEASE.
  - IDLE: if req≠0 at edge t, pick the winner w by the rotated order and go to HOLD. In the same edge: grant=1<<w, grant_valid=1, grant_idx=w, busy_cycles=0, last_ptr=w. Latency is 1 cycle from req to grant.
  - IDLE with req=0: stay in IDLE; outputs stay at their reset values.
  - HOLD: while req[w]=1, keep the grant and increment busy_cycles (saturating at 255). Requests from other requesters are ignored.
  - HOLD with req[w]=0 at edge t: grant clears at t (grant=0, grant_valid=0, grant_idx=8'hF0) and the FSM goes to RELEASE.
  - RELEASE: one mandatory bubble cycle with no grant, then IDLE. The next grant therefore appears no earlier than 2 cycles after the release edge.
- Simultaneous events:
  - Owner drops its request while others request: owner releases, bubble cycle, then others are arbitrated with last_ptr=w.
  - Owner re-asserts its request after a release: it has the lowest priority if others are requesting.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid equals the OR of grant.
  - grant_idx equals the encoded grant, or 8'hF0 when grant=0.
- Requesters are never starved: each requester waits at most N_REQ-1 other grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: in HOLD, when busy_cycles reaches MAX_HOLD-1 and req[w] is still high, force a release at the next edge, exactly as if req[w] had dropped (including the RELEASE bubble). The owner must re-win arbitration, which rotates it to lowest priority.
- Not defined: no timeout; the hold lasts indefinitely. busy_cycles remains as a pure statistic.

Decomposition:
- Shared package arb_pkg:
  - State enum {IDLE, HOLD, RELEASE}.
  - localparam NO_GRANT = 8'hF0.
  - Default N_REQ.
  - A function for one-hot-to-index conversion.
- One natural sub-module, rr_mask_encoder (combinational):
  - Inputs: req, last_ptr.
  - Output: winner index and found flag.
  - Implemented as two highest-index-first priority searches: first over req masked to indices below last_ptr, then, if none is found, over the full req.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> grant=0, grant_valid=0, grant_idx=8'hF0 throughout.
- After reset, req=16'h8001 -> one cycle later grant=16'h8000, grant_idx=15.
  - Drop req[15] -> grant clears that edge, one bubble cycle, then grant=16'h0001, grant_idx=0.
- All 16 requests held high; each owner drops its request after 3 cycles then re-asserts -> grant order is 15,14,…,0,15; every owner sees busy_cycles count 0,1,2.
- Owner 5 holds, req=16'hFFFF, rst pulsed high one cycle mid-hold -> next edge: all outputs at reset values. The next grant goes to 15, not 4.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=16'h0030 held constantly -> grant to 5 for 4 cycles, bubble, grant to 4 for 4 cycles, bubble, grant to 5. Without the macro, 5 holds indefinitely.
- Request appears on the same edge as the RELEASE bubble -> it is not granted until after IDLE; verify the 2-cycle minimum gap between grants.
